spatial_conv_stream_v2: RTL
===========================

SPATIAL_CONV_STREAM_V2 -- requirements
Module: spatial_conv_stream_v2

Interface
REQ-001 SHALL have parameter C_IN, default 8, meaning input channels per time-step (>=2).
REQ-002 SHALL have parameter C_OUT, default 8, meaning output features per time-step (>=1).
REQ-003 SHALL have parameter DATA_W, default 16, meaning sample/output/bias width, signed Q8.8.
REQ-004 SHALL have parameter COEF_W, default 16, meaning weight width, signed Q8.8.
REQ-005 SHALL have parameter ACC_W, default 48, meaning accumulator width.
REQ-006 SHALL have parameter SHIFT, default 8, meaning product-to-output fractional shift (>=1).
REQ-007 SHALL have parameter ROUND, default 1, meaning 1 = round-half-up before shift, 0 = truncate.
REQ-008 SHALL have parameter SAT, default 1, meaning 1 = saturate output to DATA_W, 0 = wrap (keep low DATA_W bits).
REQ-009 SHALL have ports: clk input 1 clock; rst_n input 1 asynchronous active-low reset.
REQ-010 SHALL have ports: x_valid input 1; x_ready output 1; x_in input DATA_W signed, channel-interleaved samples (ch0 first).
REQ-011 SHALL have ports: y_valid output 1; y_ready input 1; y_out output DATA_W signed; y_last output 1, high with feature C_OUT-1.
REQ-012 SHALL have ports: w_we input 1; w_feat input clog2(C_OUT); w_chan input clog2(C_IN); w_data input COEF_W signed, weight write.
REQ-013 SHALL have ports: b_we input 1; b_feat input clog2(C_OUT); b_data input DATA_W signed, bias write.
REQ-014 SHALL have ports: busy output 1, high in COMPUTE or OUT; wr_err output 1, one-cycle pulse on a rejected write.

Function
REQ-015 SHALL implement FSM LOAD -> COMPUTE -> OUT -> (COMPUTE | LOAD).
REQ-016 LOAD: x_ready=1; each x_valid&&x_ready stores x_in into sample buffer[ch], ch++; on ch==C_IN-1 accept, ch<=0, f<=0, go COMPUTE.
REQ-017 COMPUTE: one MAC per cycle, acc <= (c==0 ? bias_ext[f] : acc) + buf[c]*W[f][c], sign-extended to ACC_W; after c==C_IN-1, go OUT.
REQ-018 bias_ext[f] SHALL be b[f] sign-extended to ACC_W and shifted left by SHIFT.
REQ-019 Output value SHALL be (acc + (ROUND ? 2^(SHIFT-1) : 0)) >>> SHIFT, then clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] if SAT, else truncated.
REQ-020 OUT: y_valid=1, y_out and y_last stable until y_valid&&y_ready; on handshake, if f==C_OUT-1 go LOAD, else f++ and go COMPUTE.
REQ-021 x_ready SHALL be 0 in COMPUTE and OUT (backpressure); y_valid SHALL be 0 outside OUT.
REQ-022 Latency: with y_ready=1, y_valid for feature 0 SHALL rise on the (C_IN+1)th rising edge after the edge accepting the last channel; each following feature C_IN+1 cycles after the previous handshake.
REQ-023 Weight/bias writes SHALL take effect on the next edge only in LOAD with ch==0; otherwise write ignored and wr_err pulses 1 cycle.
REQ-024 Simultaneous w_we and b_we in LOAD with ch==0 SHALL both succeed; simultaneous write and x accept with ch==0 SHALL both succeed.
REQ-025 Weight and bias storage SHALL be register-based, unaffected by reset (undefined until written).

Reset
REQ-026 rst_n low SHALL asynchronously force state LOAD, ch=0, f=0, acc=0, x_ready=0, y_valid=0, y_out=0, y_last=0, busy=0, wr_err=0.
REQ-027 x_ready SHALL rise on the first clk edge after rst_n deasserts; reset mid-COMPUTE or mid-OUT SHALL discard partial results with no output.

Verification
REQ-028 C_IN=2,C_OUT=2, W0={256,256}, W1={512,-256}, bias 0, inputs 256,512 -> y_out 768 (y_last=0), then 0 (y_last=1).
REQ-029 SAT=1: all weights 0x7FFF, inputs 0x7FFF -> y_out 0x7FFF; inputs 0x8000 with weights 0x7FFF -> 0x8000.
REQ-030 W=128, input 1, bias 0: ROUND=1 -> y_out 1; ROUND=0 -> y_out 0; bias 256 adds exactly 256.
REQ-031 y_ready low 5 cycles in OUT -> y_valid, y_out, y_last stable, x_ready=0; output completes on y_ready rise.
REQ-032 w_we asserted during COMPUTE -> wr_err pulse, weights unchanged in next frame result.
REQ-033 rst_n asserted in COMPUTE -> y_valid=0 immediately; next full frame produces correct results from ch0.

Source files
------------

// File: rtl/spatial_conv_stream_v2.sv
// -----------------------------------------------------------------------------
// spatial_conv_stream_v2
// Streaming 1x1 (spatial) convolution: collects one time-step of C_IN
// channel-interleaved samples, then produces C_OUT features, each the dot
// product of the sample vector with one weight row plus a bias, in fixed point.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   x_valid/x_ready/x_in       sample input stream, channel 0 first
//   y_valid/y_ready/y_out      feature output stream
//   y_last                     marks feature C_OUT-1 of the time-step
//   w_we/w_feat/w_chan/w_data  weight write port
//   b_we/b_feat/b_data         bias write port
//   busy                       high while computing or presenting outputs
//   wr_err                     one-cycle pulse when a write is rejected
// -----------------------------------------------------------------------------
module spatial_conv_stream_v2 #(
    parameter int C_IN   = 8,
    parameter int C_OUT  = 8,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 48,
    parameter int SHIFT  = 8,
    parameter int ROUND  = 1,
    parameter int SAT    = 1,
    localparam int FW    = (C_OUT > 1) ? $clog2(C_OUT) : 1,
    localparam int CW    = (C_IN > 1) ? $clog2(C_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic signed [DATA_W-1:0] x_in,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic signed [DATA_W-1:0] y_out,
    output logic                     y_last,
    input  logic                     w_we,
    input  logic [FW-1:0]            w_feat,
    input  logic [CW-1:0]            w_chan,
    input  logic signed [COEF_W-1:0] w_data,
    input  logic                     b_we,
    input  logic [FW-1:0]            b_feat,
    input  logic signed [DATA_W-1:0] b_data,
    output logic                     busy,
    output logic                     wr_err
);

    // MAC counter runs 0..C_IN; the extra count is the output-formatting cycle.
    localparam int CNTW = $clog2(C_IN + 1);
    localparam int PW   = DATA_W + COEF_W;
    localparam logic signed [ACC_W-1:0] RND_C =
        (ROUND != 0) ? ({{(ACC_W-1){1'b0}}, 1'b1} << (SHIFT - 1)) : {ACC_W{1'b0}};
    localparam logic signed [ACC_W-1:0] MAX_C = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_C = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    state_t                     state_r, state_s;
    logic [CW-1:0]              ch_r;
    logic [FW-1:0]              f_r;
    logic [CNTW-1:0]            c_r;
    logic signed [ACC_W-1:0]    acc_r;
    logic signed [DATA_W-1:0]   smp_r [C_IN];
    logic signed [COEF_W-1:0]   w_mem [C_OUT][C_IN];
    logic signed [DATA_W-1:0]   b_mem [C_OUT];
    logic                       x_ready_r, y_valid_r, y_last_r, busy_r, wr_err_r;
    logic signed [DATA_W-1:0]   y_out_r;

    logic                       x_fire_s, y_fire_s, wr_open_s, w_ok_s, b_ok_s, rej_s;
    logic [CW-1:0]              c_idx_s;
    logic signed [PW-1:0]       prod_s;
    logic signed [ACC_W-1:0]    acc_next_s;

    // Round, arithmetic shift, then clamp or wrap to the output width.
    function automatic logic signed [DATA_W-1:0] quantize(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        logic signed [DATA_W-1:0] q;
        s = (a + RND_C) >>> SHIFT;
        if (SAT != 0) begin
            if (s > MAX_C) begin
                q = MAX_C[DATA_W-1:0];
            end else if (s < MIN_C) begin
                q = MIN_C[DATA_W-1:0];
            end else begin
                q = s[DATA_W-1:0];
            end
        end else begin
            q = s[DATA_W-1:0];
        end
        return q;
    endfunction

    assign x_ready = x_ready_r;
    assign y_valid = y_valid_r;
    assign y_out   = y_out_r;
    assign y_last  = y_last_r;
    assign busy    = busy_r;
    assign wr_err  = wr_err_r;

    // Handshakes, write qualification and the MAC datapath.
    always_comb begin
        x_fire_s  = x_valid && x_ready_r && (state_r == S_LOAD);
        y_fire_s  = y_valid_r && y_ready;
        wr_open_s = (state_r == S_LOAD) && (ch_r == {CW{1'b0}});
        w_ok_s    = w_we && wr_open_s && (w_feat <= FW'(C_OUT - 1)) && (w_chan <= CW'(C_IN - 1));
        b_ok_s    = b_we && wr_open_s && (b_feat <= FW'(C_OUT - 1));
        rej_s     = (w_we && !w_ok_s) || (b_we && !b_ok_s);
        c_idx_s   = (c_r < CNTW'(C_IN)) ? c_r[CW-1:0] : {CW{1'b0}};
        prod_s    = smp_r[c_idx_s] * w_mem[f_r][c_idx_s];
        // First MAC of a feature starts from the bias aligned to the product scale.
        if (c_r == {CNTW{1'b0}}) begin
            acc_next_s = ({{(ACC_W-DATA_W){b_mem[f_r][DATA_W-1]}}, b_mem[f_r]} <<< SHIFT)
                       + {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};
        end else begin
            acc_next_s = acc_r + {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};
        end
    end

    // Next-state logic for LOAD -> COMPUTE -> OUT -> (COMPUTE | LOAD).
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_LOAD: begin
                if (x_fire_s && (ch_r == CW'(C_IN - 1))) begin
                    state_s = S_COMPUTE;
                end else begin
                    state_s = S_LOAD;
                end
            end
            S_COMPUTE: begin
                if (c_r == CNTW'(C_IN)) begin
                    state_s = S_OUT;
                end else begin
                    state_s = S_COMPUTE;
                end
            end
            S_OUT: begin
                if (y_fire_s) begin
                    state_s = (f_r == FW'(C_OUT - 1)) ? S_LOAD : S_COMPUTE;
                end else begin
                    state_s = S_OUT;
                end
            end
            default: state_s = S_LOAD;
        endcase
    end

    // State register, counters, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_LOAD;
            ch_r      <= {CW{1'b0}};
            f_r       <= {FW{1'b0}};
            c_r       <= {CNTW{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            x_ready_r <= 1'b0;
            y_valid_r <= 1'b0;
            y_out_r   <= {DATA_W{1'b0}};
            y_last_r  <= 1'b0;
            busy_r    <= 1'b0;
            wr_err_r  <= 1'b0;
            for (int i = 0; i < C_IN; i++) begin
                smp_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_r   <= state_s;
            x_ready_r <= (state_s == S_LOAD);
            y_valid_r <= (state_s == S_OUT);
            busy_r    <= (state_s != S_LOAD);
            wr_err_r  <= rej_s;
            case (state_r)
                S_LOAD: begin
                    if (x_fire_s) begin
                        smp_r[ch_r] <= x_in;
                        if (ch_r == CW'(C_IN - 1)) begin
                            ch_r <= {CW{1'b0}};
                            f_r  <= {FW{1'b0}};
                            c_r  <= {CNTW{1'b0}};
                        end else begin
                            ch_r <= ch_r + CW'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (c_r == CNTW'(C_IN)) begin
                        y_out_r  <= quantize(acc_r);
                        y_last_r <= (f_r == FW'(C_OUT - 1));
                    end else begin
                        acc_r <= acc_next_s;
                        c_r   <= c_r + CNTW'(1);
                    end
                end
                S_OUT: begin
                    if (y_fire_s && (f_r != FW'(C_OUT - 1))) begin
                        f_r <= f_r + FW'(1);
                        c_r <= {CNTW{1'b0}};
                    end
                end
                default: begin
                    c_r <= {CNTW{1'b0}};
                end
            endcase
        end
    end

    // Coefficient storage: plain registers, deliberately outside reset.
    always_ff @(posedge clk) begin
        if (w_ok_s) begin
            w_mem[w_feat][w_chan] <= w_data;
        end
        if (b_ok_s) begin
            b_mem[b_feat] <= b_data;
        end
    end

endmodule
